hazard_scoreboard_unit: RTL

Parametrised successor to the MIPS16 hazard detection unit. It replaces fixed EX/MEM/WB destination compares with a per-register scoreboard of remaining-latency counters. This supports variable-latency producers such as loads and multi-cycle multiply/divide, any number of decode source operands, and any register-file width. It sits beside the ID stage and drives the active-low pipeline stall. It also provides a saturating stall-cycle performance counter and a sticky watchdog error.

---
 rtl/hazard_scoreboard_if.sv | 48 ++++
 rtl/hazard_scoreboard_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the decode-side request signals and the stall/status results that
// pass between the ID stage and hazard_scoreboard_unit.
//   master : the ID stage. It drives the source/destination descriptors,
//            issue and flush, and receives the stall and status outputs.
//   slave  : hazard_scoreboard_unit.
// Signals:
//   decoding_op_src_valid [NUM_SRC]      per-source "operand is read" flags
//   decoding_op_src       [NUM_SRC*RA_W] packed source addresses (i at i*RA_W)
//   decoding_issue                       ID instruction tries to advance
//   decoding_dest_valid                  issuing instruction writes a register
//   decoding_op_dest      [RA_W]         destination address
//   decoding_dest_lat     [CNT_W]        cycles until result is forwardable
//   flush                                clears the whole scoreboard
//   pipeline_stall_n                     0 = hold IF/ID and insert a bubble
//   stall_cycles          [PERF_W]       saturating stalled-cycle count
//   stall_err                            sticky watchdog error
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int RA_W    = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 3,
  parameter int PERF_W  = 16
);
  logic [NUM_SRC-1:0]      decoding_op_src_valid;
  logic [NUM_SRC*RA_W-1:0] decoding_op_src;
  logic                    decoding_issue;
  logic                    decoding_dest_valid;
  logic [RA_W-1:0]         decoding_op_dest;
  logic [CNT_W-1:0]        decoding_dest_lat;
  logic                    flush;
  logic                    pipeline_stall_n;
  logic [PERF_W-1:0]       stall_cycles;
  logic                    stall_err;

  modport master (
    output decoding_op_src_valid, decoding_op_src, decoding_issue,
           decoding_dest_valid, decoding_op_dest, decoding_dest_lat, flush,
    input  pipeline_stall_n, stall_cycles, stall_err
  );

  modport slave (
    input  decoding_op_src_valid, decoding_op_src, decoding_issue,
           decoding_dest_valid, decoding_op_dest, decoding_dest_lat, flush,
    output pipeline_stall_n, stall_cycles, stall_err
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
// Per-register scoreboard of remaining-latency counters beside the ID stage.
// A read of a register whose counter is nonzero stalls the pipeline in the
// same cycle. Accepted writes load their latency into the destination
// counter. Every nonzero counter decrements once per cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hazard_scoreboard_if.slave (decode request, stall and status)
// The bus interface must be built with CNT_W = $clog2(MAX_LAT+1) and the same
// RA_W/NUM_SRC/PERF_W as this module.
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int RA_W     = 3,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 4,
  parameter int ZERO_REG = 1,
  parameter int PERF_W   = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  localparam int NREG  = 2 ** RA_W;
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0]  LAT_MAX  = CNT_W'(MAX_LAT);
  localparam logic [CNT_W:0]    RUN_TRIP = (CNT_W + 1)'(MAX_LAT + 1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  // All counters are packed so that entry r lives at [r*CNT_W +: CNT_W].
  logic [NREG*CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]        stall_run_q, stall_run_d;
  logic [PERF_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic                  stall_err_q, stall_err_d;

  logic [NUM_SRC-1:0]    haz;
  logic                  stall_n;
  logic                  accept;
  logic                  write_en;
  logic [CNT_W-1:0]      lat_sat;

  function automatic logic is_zero_reg(input logic [RA_W-1:0] addr);
    return (ZERO_REG == 1) && (addr == '0);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input logic [NREG*CNT_W-1:0] v,
                                              input logic [RA_W-1:0] addr);
    return v[int'(addr)*CNT_W +: CNT_W];
  endfunction

  function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] lat);
    if (lat > LAT_MAX) begin
      return LAT_MAX;
    end else begin
      return lat;
    end
  endfunction

  // Decrement saturating at zero. A write that hits this entry keeps the
  // longer of the old remaining window and the new latency, so a younger
  // write can never shorten a pending window (WAW).
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                input logic hit,
                                                input logic [CNT_W-1:0] lat);
    logic [CNT_W-1:0] dec;
    if (cur != '0) begin
      dec = cur - CNT_W'(1);
    end else begin
      dec = '0;
    end
    if (hit && (lat > dec)) begin
      return lat;
    end else begin
      return dec;
    end
  endfunction

  // Same-cycle hazard check for every decoded source operand.
  always_comb begin
    haz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      haz[i] = bus.decoding_op_src_valid[i]
             && (cnt_of(cnt_q, bus.decoding_op_src[i*RA_W +: RA_W]) != '0)
             && !is_zero_reg(bus.decoding_op_src[i*RA_W +: RA_W]);
    end
  end

  assign stall_n  = ~|haz;
  assign accept   = bus.decoding_issue & stall_n & ~bus.flush;
  assign write_en = accept & bus.decoding_dest_valid & ~is_zero_reg(bus.decoding_op_dest);
  assign lat_sat  = clamp_lat(bus.decoding_dest_lat);

  // Scoreboard next state: flush wins over decrement and over a same-cycle write.
  always_comb begin
    cnt_d = '0;
    if (bus.flush) begin
      cnt_d = '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r*CNT_W +: CNT_W] = next_cnt(cnt_q[r*CNT_W +: CNT_W],
                                           write_en && (bus.decoding_op_dest == RA_W'(r)),
                                           lat_sat);
      end
    end
  end

  // Stall statistics: saturating stall counter and the consecutive-stall watchdog.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    stall_run_d    = stall_run_q;
    if (!stall_n && (stall_cycles_q != PERF_MAX)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    // A single producer can hold a stall for at most MAX_LAT cycles, so a run
    // of MAX_LAT+1 means the scoreboard state is corrupt.
    if (bus.flush || stall_n) begin
      stall_run_d = '0;
    end else if (stall_run_q != RUN_TRIP) begin
      stall_run_d = stall_run_q + (CNT_W + 1)'(1);
    end else begin
      stall_run_d = stall_run_q;
    end
    stall_err_d = stall_err_q | (stall_run_d == RUN_TRIP);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      stall_run_q    <= '0;
      stall_cycles_q <= '0;
      stall_err_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      stall_run_q    <= stall_run_d;
      stall_cycles_q <= stall_cycles_d;
      stall_err_q    <= stall_err_d;
    end
  end

  // The stall must act in the same cycle as the decode, so it stays combinational.
  assign bus.pipeline_stall_n = stall_n;
  assign bus.stall_cycles     = stall_cycles_q;
  assign bus.stall_err        = stall_err_q;

endmodule
